// File: rtl/fetch.sv
// Instruction fetch stage: holds the PC, issues one imem read at a time and hands
// the returned word to decode. `FETCH_MISALIGN_TRAP_EN` redirects misaligned targets to mtvec.
module fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          SEL_PC_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    imem_req,
  output logic [31:0]             imem_addr,
  input  logic                    imem_ready,
  input  logic                    imem_rvalid,
  input  logic [31:0]             imem_rdata,
  output logic [31:0]             code,
  output logic [31:0]             pc,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  input  logic [SEL_PC_WIDTH-1:0] pc_sel,
  input  logic [31:0]             imm,
  input  logic [31:0]             rs1_data,
  input  logic [31:0]             csr_mtvec,
  input  logic [31:0]             csr_mepc,
  output logic                    misalign_exc,
  output logic [31:0]             misalign_addr,
  output logic [1:0]              dbg_state
);

  localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_ADD4  = SEL_PC_WIDTH'(0);
  localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JAL   = SEL_PC_WIDTH'(1);
  localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JALR  = SEL_PC_WIDTH'(2);
  localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_MTVEC = SEL_PC_WIDTH'(3);
  localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_MEPC  = SEL_PC_WIDTH'(4);
  localparam logic [31:0]             NOP          = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] pc_out_q;
  logic [31:0] code_q;
  logic [31:0] next_raw;
  logic [31:0] next_pc;
  logic        handshake;

  // Handshake: an instruction moves to decode in a cycle where inst_valid && inst_ready;
  // imem accepts a request when imem_req && imem_ready; imem_rvalid counts only in S_WAIT.
  assign handshake = (state == S_VALID) && inst_ready;

  always_comb begin
    next_raw = pc_q + 32'd4;
    case (pc_sel)
      SEL_PC_ADD4:  next_raw = pc_q + 32'd4;
      SEL_PC_JAL:   next_raw = pc_q + imm;
      SEL_PC_JALR:  next_raw = (rs1_data + imm) & ~32'h1;
      SEL_PC_MTVEC: next_raw = csr_mtvec;
      SEL_PC_MEPC:  next_raw = csr_mepc;
      default:      next_raw = pc_q + 32'd4;
    endcase
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        exc_q;
  logic [31:0] exc_addr_q;

  // Bit 0 is dropped on the aligned path too so imem_addr is always word aligned.
  assign next_pc = next_raw[1] ? (csr_mtvec & 32'hFFFF_FFFC) : (next_raw & 32'hFFFF_FFFC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_q      <= 1'b0;
      exc_addr_q <= 32'h0;
    end else begin
      exc_q <= handshake && next_raw[1];
      if (handshake && next_raw[1]) exc_addr_q <= next_raw;
    end
  end

  assign misalign_exc  = exc_q;
  assign misalign_addr = exc_addr_q;
`else
  assign next_pc       = next_raw & 32'hFFFF_FFFC;
  assign misalign_exc  = 1'b0;
  assign misalign_addr = 32'h0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      code_q   <= NOP;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            code_q   <= imem_rdata;
            pc_out_q <= pc_q;
            state    <= S_VALID;
          end
        end
        S_VALID: begin
          if (inst_ready) begin
            pc_q  <= next_pc;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  // pc is a separate copy so it only moves when a new word arrives, not at the handshake.
  assign imem_req   = (state == S_REQ);
  assign imem_addr  = pc_q;
  assign inst_valid = (state == S_VALID);
  assign code       = code_q;
  assign pc         = pc_out_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the fetch stage.
module tb_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [2:0]  ADD4 = 3'd0, JAL = 3'd1, JALR = 3'd2, MTVEC = 3'd3, MEPC = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] code, pc;
  logic        inst_valid, inst_ready;
  logic [2:0]  pc_sel;
  logic [31:0] imm, rs1_data, csr_mtvec, csr_mepc;
  logic        misalign_exc;
  logic [31:0] misalign_addr;
  logic [1:0]  dbg_state;

  fetch #(.RESET_PC(RST_PC), .SEL_PC_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .code(code), .pc(pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .pc_sel(pc_sel), .imm(imm), .rs1_data(rs1_data),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .misalign_exc(misalign_exc), .misalign_addr(misalign_addr),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  // model: 0 = wants a request, 1 = read outstanding, 2 = holding an instruction
  int          m_phase;
  logic [31:0] m_pc, m_code, m_pc_out, m_exc_addr;
  logic        m_exc;

  // memory responder state
  bit          mem_pending;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_cfg = 1;
  bit          spur_en = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_pc = RST_PC; m_code = 32'h0000_0013; m_pc_out = RST_PC;
    m_exc = 1'b0; m_exc_addr = 32'h0;
    mem_pending = 0; imem_rvalid = 1'b0;
  endtask

  task automatic model_update();
    logic [31:0] raw;
    m_exc = 1'b0;
    if (m_phase == 0) begin
      if (imem_ready) m_phase = 1;
    end else if (m_phase == 1) begin
      if (imem_rvalid) begin
        m_phase = 2; m_code = mem_word(m_pc); m_pc_out = m_pc;
      end
    end else if (inst_ready) begin
      case (pc_sel)
        JAL:     raw = m_pc + imm;
        JALR:    raw = (rs1_data + imm) & ~32'h1;
        MTVEC:   raw = csr_mtvec;
        MEPC:    raw = csr_mepc;
        default: raw = m_pc + 32'd4;
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      if (raw[1]) begin
        m_exc = 1'b1; m_exc_addr = raw; m_pc = csr_mtvec & ~32'h3;
      end else m_pc = raw & ~32'h3;
`else
      m_pc = raw & ~32'h3;
`endif
      m_phase = 0;
    end
  endtask

  // driver: memory response for the coming edge, acceptance bookkeeping
  task automatic mem_drive();
    if (mem_pending) begin
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1; imem_rdata = mem_word(mem_addr); mem_pending = 0;
      end else begin
        imem_rvalid = 1'b0; mem_cnt--;
      end
    end else if (spur_en && inst_valid && ($urandom_range(0, 3) == 0)) begin
      imem_rvalid = 1'b1; imem_rdata = $urandom;
    end else begin
      imem_rvalid = 1'b0;
    end
    if (imem_req && imem_ready) begin
      mem_pending = 1; mem_cnt = lat_cfg - 1; mem_addr = imem_addr;
    end
  endtask

  task automatic compare();
    if (rst_n) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, (m_phase == 0)});
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, (m_phase == 2)});
      if (m_phase == 0) chk("imem_addr", imem_addr, m_pc);
      chk("code", code, m_code);
      chk("pc", pc, m_pc_out);
      chk("misalign_exc", {31'b0, misalign_exc}, {31'b0, m_exc});
      chk("misalign_addr", misalign_addr, m_exc_addr);
    end
  endtask

  task automatic tick();
    mem_drive();
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!inst_valid && k < 20) begin
      tick(); k++;
    end
    if (!inst_valid) begin
      n_tests++; n_fail++;
      $display("FAIL wait_valid: timeout after %0d cycles", k);
    end
  endtask

  task automatic handshake(input string name, input logic [31:0] cur_pc, input logic [2:0] sel,
                           input logic [31:0] im, input logic [31:0] rs1, input logic [31:0] exp_next);
    imem_ready = 1'b1; lat_cfg = 1; inst_ready = 1'b0;
    wait_valid();
    chk({name, "_pc"}, pc, cur_pc);
    chk({name, "_code"}, code, mem_word(cur_pc));
    pc_sel = sel; imm = im; rs1_data = rs1; inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk({name, "_req"}, {31'b0, imem_req}, 32'd1);
    chk({name, "_next"}, imem_addr, exp_next);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    compare();
  endtask

  initial begin
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    pc_sel = ADD4; imm = 32'h0; rs1_data = 32'h0; csr_mtvec = 32'h80; csr_mepc = 32'h0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    compare();

    // reset fetch
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_code", code, 32'h13);
    chk("rst_pc", pc, 32'h100);
    imem_ready = 1'b1; lat_cfg = 1;
    tick();
    chk("lat_n1_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("lat_n2_valid", {31'b0, inst_valid}, 32'd1);
    chk("lat_n2_code", code, 32'h0050_0093);
    chk("lat_n2_pc", pc, 32'h100);
    pc_sel = ADD4; inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("first_next", imem_addr, 32'h104);

    // backpressure
    wait_valid();
    repeat (5) begin
      tick();
      chk("bp_valid", {31'b0, inst_valid}, 32'd1);
      chk("bp_req", {31'b0, imem_req}, 32'd0);
      chk("bp_pc", pc, 32'h104);
      chk("bp_code", code, mem_word(32'h104));
    end
    handshake("bp_release", 32'h104, ADD4, 32'h0, 32'h0, 32'h108);

    csr_mepc = 32'h208;
    handshake("mepc", 32'h108, MEPC, 32'h0, 32'h0, 32'h208);

    // request stall keeps the address
    imem_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_req", {31'b0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, 32'h208);
    end

    handshake("jal_back", 32'h208, JAL, 32'hFFFF_FFF8, 32'h0, 32'h200);
    handshake("jal_neg", 32'h200, JAL, 32'hFFFF_FFF0, 32'h0, 32'h1F0);
    handshake("jalr", 32'h1F0, JALR, 32'h4, 32'h301, 32'h304);
    csr_mtvec = 32'h80;
    handshake("mtvec", 32'h304, MTVEC, 32'h0, 32'h0, 32'h80);
`ifdef FETCH_MISALIGN_TRAP_EN
    handshake("misalign", 32'h80, JAL, 32'h18A, 32'h0, 32'h80);
    chk("misalign_exc_pulse", {31'b0, misalign_exc}, 32'd1);
    chk("misalign_addr_val", misalign_addr, 32'h20A);
`else
    handshake("misalign", 32'h80, JAL, 32'h18A, 32'h0, 32'h208);
    chk("misalign_exc_tied", {31'b0, misalign_exc}, 32'd0);
`endif

    // reset while a read is outstanding; the late response must be dropped
    imem_ready = 1'b1; lat_cfg = 3;
    tick();
    chk("wait_req", {31'b0, imem_req}, 32'd0);
    rst_n = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    compare();
    chk("rst_wait_addr", imem_addr, 32'h100);
    chk("rst_wait_code", code, 32'h13);
    handshake("after_rst", 32'h100, ADD4, 32'h0, 32'h0, 32'h104);

    // randomized traffic
    spur_en = 1;
    for (int i = 0; i < 4000; i++) begin
      imem_ready = ($urandom_range(0, 3) != 0);
      inst_ready = ($urandom_range(0, 1) != 0);
      pc_sel     = 3'($urandom_range(0, 7));
      imm        = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 1) != 0) imm = -imm;
      rs1_data   = $urandom;
      csr_mtvec  = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      csr_mtvec  = csr_mtvec & ~32'h3;
`endif
      csr_mepc   = $urandom;
      lat_cfg    = $urandom_range(1, 4);
      if (i == 2000) do_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
